// File: rtl/display_receiver.sv
// Serial BCD frame receiver with a multiplexed seven-segment display driver.
// The serial and display-tick inputs are asynchronous and are synchronized to internal_clock.
module display_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int DIGITS      = 4
) (
  input  logic                  internal_clock,
  input  logic                  RST,
  input  logic                  DATA_CLOCK_SIGNAL,
  input  logic                  ENABLE_SIGNAL,
  input  logic                  VALUE_SIGNAL,
  input  logic                  BOARD_CLOCK_SIGNAL,
  output logic [4*DIGITS-1:0]   VALUE_BCD,
  output logic [6:0]            SEG,
  output logic [DIGITS-1:0]     DIGIT_SEL,
  output logic                  FRAME_VALID,
  output logic                  FRAME_ERROR,
  output logic [1:0]            state_dbg
);

  localparam int FRAME_BITS = 4 * DIGITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Handshake: the serial link has no back-pressure. A bit is accepted on every
  // falling edge of the synchronized data clock; ENABLE marks data bits, and the
  // first tick with ENABLE low after a full frame commits it. FRAME_VALID and
  // FRAME_ERROR are single-cycle pulses with no acknowledge.

  logic [SYNC_STAGES-1:0] dclk_sync;
  logic [SYNC_STAGES-1:0] en_sync;
  logic [SYNC_STAGES-1:0] val_sync;
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic                   dclk_q;
  logic                   bclk_q;

  always_ff @(posedge internal_clock) begin
    if (RST) begin
      dclk_sync <= '0;
      en_sync   <= '0;
      val_sync  <= '0;
      bclk_sync <= '0;
      dclk_q    <= 1'b0;
      bclk_q    <= 1'b0;
    end else begin
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], DATA_CLOCK_SIGNAL};
      en_sync   <= {en_sync[SYNC_STAGES-2:0], ENABLE_SIGNAL};
      val_sync  <= {val_sync[SYNC_STAGES-2:0], VALUE_SIGNAL};
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BOARD_CLOCK_SIGNAL};
      dclk_q    <= dclk_sync[SYNC_STAGES-1];
      bclk_q    <= bclk_sync[SYNC_STAGES-1];
    end
  end

  logic sample_tick;
  logic mux_tick;
  logic en_s;
  logic val_s;

  // ENABLE and VALUE come from the same stage as the edge so all three stay aligned.
  assign sample_tick = dclk_q & ~dclk_sync[SYNC_STAGES-1];
  assign mux_tick    = ~bclk_q & bclk_sync[SYNC_STAGES-1];
  assign en_s        = en_sync[SYNC_STAGES-1];
  assign val_s       = val_sync[SYNC_STAGES-1];

  logic [1:0]            state;
  logic [CNT_W-1:0]      bit_count;
  logic [FRAME_BITS-1:0] shadow;
  logic [CNT_W-1:0]      bit_pos;

  // Each digit arrives MSB first, so the low two count bits are mirrored.
  assign bit_pos   = {bit_count[CNT_W-1:2], ~bit_count[1:0]};
  assign state_dbg = state;

  always_ff @(posedge internal_clock) begin
    if (RST) begin
      state       <= IDLE;
      bit_count   <= '0;
      shadow      <= '0;
      VALUE_BCD   <= '0;
      FRAME_VALID <= 1'b0;
      FRAME_ERROR <= 1'b0;
    end else begin
      FRAME_VALID <= 1'b0;
      FRAME_ERROR <= 1'b0;
      if (sample_tick) begin
        case (state)
          IDLE: begin
            if (en_s) begin
              for (int i = 0; i < FRAME_BITS; i++) begin
                shadow[i] <= (i == 3) ? val_s : 1'b0;
              end
              bit_count <= CNT_W'(1);
              state     <= SHIFT;
            end
          end
          SHIFT: begin
            if (en_s) begin
              if (bit_count == CNT_W'(FRAME_BITS)) begin
                FRAME_ERROR <= 1'b1;
                state       <= DRAIN;
              end else begin
                for (int i = 0; i < FRAME_BITS; i++) begin
                  if (CNT_W'(i) == bit_pos) shadow[i] <= val_s;
                end
                bit_count <= bit_count + 1'b1;
              end
            end else begin
              if (bit_count == CNT_W'(FRAME_BITS)) begin
                VALUE_BCD   <= shadow;
                FRAME_VALID <= 1'b1;
              end else begin
                FRAME_ERROR <= 1'b1;
              end
              bit_count <= '0;
              state     <= IDLE;
            end
          end
          DRAIN: begin
            if (!en_s) begin
              bit_count <= '0;
              state     <= IDLE;
            end
          end
          default: begin
            bit_count <= '0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

  logic [IDX_W-1:0] digit_idx;
  logic [3:0]       cur_digit;
  logic [6:0]       seg_next;

  always_comb begin
    cur_digit = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_idx == IDX_W'(d)) cur_digit = VALUE_BCD[4*d +: 4];
    end
  end

  // Segment order is {g,f,e,d,c,b,a}; 15 is shown as a dash, 10..14 are blank.
  always_comb begin
    seg_next = 7'b0000000;
    case (cur_digit)
      4'd0:  seg_next = 7'b0111111;
      4'd1:  seg_next = 7'b0000110;
      4'd2:  seg_next = 7'b1011011;
      4'd3:  seg_next = 7'b1001111;
      4'd4:  seg_next = 7'b1100110;
      4'd5:  seg_next = 7'b1101101;
      4'd6:  seg_next = 7'b1111101;
      4'd7:  seg_next = 7'b0000111;
      4'd8:  seg_next = 7'b1111111;
      4'd9:  seg_next = 7'b1101111;
      4'd15: seg_next = 7'b1000000;
      default: seg_next = 7'b0000000;
    endcase
  end

  // SEG and DIGIT_SEL are registered together from the same index so they never disagree.
  always_ff @(posedge internal_clock) begin
    if (RST) begin
      digit_idx <= '0;
      DIGIT_SEL <= '1;
      SEG       <= '0;
    end else begin
      if (mux_tick) begin
        if (digit_idx == IDX_W'(DIGITS - 1)) digit_idx <= '0;
        else                                 digit_idx <= digit_idx + 1'b1;
      end
      for (int d = 0; d < DIGITS; d++) begin
        DIGIT_SEL[d] <= (digit_idx != IDX_W'(d));
      end
      SEG <= seg_next;
    end
  end

endmodule

// File: tb/tb_display_receiver.sv
// Directed bench for display_receiver: serial frames, error paths, reset and display multiplexing.
module tb_display_receiver;

  logic        internal_clock;
  logic        RST;
  logic        DATA_CLOCK_SIGNAL;
  logic        ENABLE_SIGNAL;
  logic        VALUE_SIGNAL;
  logic        BOARD_CLOCK_SIGNAL;
  logic [15:0] VALUE_BCD;
  logic [6:0]  SEG;
  logic [3:0]  DIGIT_SEL;
  logic        FRAME_VALID;
  logic        FRAME_ERROR;
  logic [1:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  logic [15:0] exp_q[$];

  display_receiver #(.SYNC_STAGES(2), .DIGITS(4)) dut (
    .internal_clock     (internal_clock),
    .RST                (RST),
    .DATA_CLOCK_SIGNAL  (DATA_CLOCK_SIGNAL),
    .ENABLE_SIGNAL      (ENABLE_SIGNAL),
    .VALUE_SIGNAL       (VALUE_SIGNAL),
    .BOARD_CLOCK_SIGNAL (BOARD_CLOCK_SIGNAL),
    .VALUE_BCD          (VALUE_BCD),
    .SEG                (SEG),
    .DIGIT_SEL          (DIGIT_SEL),
    .FRAME_VALID        (FRAME_VALID),
    .FRAME_ERROR        (FRAME_ERROR),
    .state_dbg          (state_dbg)
  );

  // clock / reset
  initial internal_clock = 1'b0;
  always #5 internal_clock = ~internal_clock;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge internal_clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every commit must match the next expected frame value
  always @(negedge internal_clock) begin
    if (FRAME_ERROR) fe_cnt++;
    if (FRAME_VALID) begin
      fv_cnt++;
      if (exp_q.size() == 0) check("unexpected_commit", {16'h0, VALUE_BCD}, 32'hFFFF_FFFF);
      else check("commit_value", {16'h0, VALUE_BCD}, {16'h0, exp_q.pop_front()});
    end
  end

  // drivers
  task automatic send_bit(input logic en, input logic val);
    ENABLE_SIGNAL = en;
    VALUE_SIGNAL  = val;
    wait_clk(4);
    DATA_CLOCK_SIGNAL = 1'b0;
    wait_clk(4);
    DATA_CLOCK_SIGNAL = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_bits(input logic [15:0] v, input int nbits);
    int k;
    k = 0;
    for (int d = 0; d < 4; d++) begin
      for (int b = 3; b >= 0; b--) begin
        if (k < nbits) send_bit(1'b1, v[4*d+b]);
        k++;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] v, input logic expect_commit);
    if (expect_commit) exp_q.push_back(v);
    send_bits(v, 16);
    send_bit(1'b0, 1'b0);
  endtask

  task automatic mux_tick();
    BOARD_CLOCK_SIGNAL = 1'b1;
    wait_clk(8);
    BOARD_CLOCK_SIGNAL = 1'b0;
    wait_clk(8);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    wait_clk(3);
  endtask

  initial begin
    int fv0;
    int fe0;
    RST = 1'b1;
    DATA_CLOCK_SIGNAL  = 1'b1;
    ENABLE_SIGNAL      = 1'b0;
    VALUE_SIGNAL       = 1'b0;
    BOARD_CLOCK_SIGNAL = 1'b0;
    wait_clk(3);

    check("rst_value", {16'h0, VALUE_BCD}, 32'h0);
    check("rst_digit_sel", {28'h0, DIGIT_SEL}, 32'hF);
    check("rst_seg", {25'h0, SEG}, 32'h0);
    check("rst_flags", {30'h0, FRAME_VALID, FRAME_ERROR}, 32'h0);
    check("rst_state", {30'h0, state_dbg}, 32'h0);
    RST = 1'b0;
    wait_clk(6);

    // Test 1: nominal frame, digits 4,3,2,1
    send_frame(16'h1234, 1'b1);
    wait_clk(2);
    check("t1_value", {16'h0, VALUE_BCD}, 32'h1234);
    check("t1_fv_count", fv_cnt, 1);
    check("t1_fe_count", fe_cnt, 0);

    // Test 2: short frame of 10 bits, then a full 9999 frame
    send_bits(16'hAAAA, 10);
    send_bit(1'b0, 1'b0);
    wait_clk(2);
    check("t2_fe_count", fe_cnt, 1);
    check("t2_value_kept", {16'h0, VALUE_BCD}, 32'h1234);
    check("t2_state_idle", {30'h0, state_dbg}, 32'h0);
    send_frame(16'h9999, 1'b1);
    wait_clk(2);
    check("t2_value", {16'h0, VALUE_BCD}, 32'h9999);
    check("t2_fv_count", fv_cnt, 2);

    // Test 3: ENABLE held for 20 ticks; error on tick 17
    fe0 = fe_cnt;
    fv0 = fv_cnt;
    send_bits(16'h5555, 16);
    check("t3_no_err_at_16", fe_cnt, fe0);
    send_bit(1'b1, 1'b0);
    check("t3_err_at_17", fe_cnt, fe0 + 1);
    check("t3_state_drain", {30'h0, state_dbg}, 32'h2);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    check("t3_still_drain", {30'h0, state_dbg}, 32'h2);
    send_bit(1'b0, 1'b0);
    wait_clk(2);
    check("t3_state_idle", {30'h0, state_dbg}, 32'h0);
    check("t3_single_err", fe_cnt, fe0 + 1);
    check("t3_no_commit", fv_cnt, fv0);
    check("t3_value_kept", {16'h0, VALUE_BCD}, 32'h9999);

    // Test 5: reset after 7 bits, then full frame 5,6,7,8
    send_bits(16'h3333, 7);
    pulse_reset();
    check("t5_rst_value", {16'h0, VALUE_BCD}, 32'h0);
    check("t5_rst_digit_sel", {28'h0, DIGIT_SEL}, 32'hF);
    check("t5_rst_seg", {25'h0, SEG}, 32'h0);
    check("t5_rst_flags", {30'h0, FRAME_VALID, FRAME_ERROR}, 32'h0);
    check("t5_rst_state", {30'h0, state_dbg}, 32'h0);
    RST = 1'b0;
    wait_clk(6);
    fv0 = fv_cnt;
    send_frame(16'h8765, 1'b1);
    wait_clk(2);
    check("t5_value", {16'h0, VALUE_BCD}, 32'h8765);
    check("t5_fv_count", fv_cnt, fv0 + 1);

    // Test 6: back-to-back frames separated by one ENABLE=0 tick
    send_frame(16'h1357, 1'b1);
    check("t6_first_value", {16'h0, VALUE_BCD}, 32'h1357);
    send_frame(16'h2468, 1'b1);
    wait_clk(2);
    check("t6_second_value", {16'h0, VALUE_BCD}, 32'h2468);
    check("t6_fv_count", fv_cnt, fv0 + 3);

    // Test 4: mux and decode of F012 starting from index 0
    pulse_reset();
    RST = 1'b0;
    wait_clk(6);
    send_frame(16'hF012, 1'b1);
    wait_clk(2);
    check("t4_sel_idx0", {28'h0, DIGIT_SEL}, 32'hE);
    check("t4_seg_idx0", {25'h0, SEG}, 32'h5B);
    mux_tick();
    check("t4_sel_idx1", {28'h0, DIGIT_SEL}, 32'hD);
    check("t4_seg_idx1", {25'h0, SEG}, 32'h06);
    mux_tick();
    check("t4_sel_idx2", {28'h0, DIGIT_SEL}, 32'hB);
    check("t4_seg_idx2", {25'h0, SEG}, 32'h3F);
    mux_tick();
    check("t4_sel_idx3", {28'h0, DIGIT_SEL}, 32'h7);
    check("t4_seg_idx3", {25'h0, SEG}, 32'h40);
    mux_tick();
    check("t4_sel_wrap", {28'h0, DIGIT_SEL}, 32'hE);
    check("t4_seg_wrap", {25'h0, SEG}, 32'h5B);

    // blank codes: digit1 = A shows nothing, digit0 = 0
    send_frame(16'h00A0, 1'b1);
    wait_clk(2);
    check("t4b_seg_zero", {25'h0, SEG}, 32'h3F);
    mux_tick();
    check("t4b_sel_idx1", {28'h0, DIGIT_SEL}, 32'hD);
    check("t4b_seg_blank", {25'h0, SEG}, 32'h00);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
